// File: rtl/axis_lrelu_config_framer_pkg.sv
// rtl/axis_lrelu_config_framer_pkg.sv - shared constants for the LReLU config framer
// Purpose : Holds the state encodings and the config-beat counts and tuser bit position.
//           The LReLU engine uses the same values, so both ends agree on the config framing.
// Ports   : none (package)
package axis_lrelu_config_framer_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CONFIG = 2'd1;
   localparam logic [1:0] ST_DATA   = 2'd2;

   // Config beats per iteration: D1 + A2 + B6 (3x3) or D1 + A2 + B2 (1x1)
   localparam int LRELU_BEATS_CONFIG_3X3 = 9;
   localparam int LRELU_BEATS_CONFIG_1X1 = 5;
   localparam int LRELU_I_IS_1X1         = 2;

endpackage

// File: rtl/axis_lrelu_config_framer_pipe_reg.sv
// rtl/axis_lrelu_config_framer_pipe_reg.sv - single-stage valid/ready output register
// Purpose : Provides one registered AXI-Stream stage. The register loads whenever it is
//           empty or being drained. Its payload holds stable while it is stalled.
// Ports   : aclk/aresetn    clock, synchronous active-low reset
//           i_valid/i_data  upstream beat, accepted whenever o_en=1
//           o_en            stage can take a beat this cycle (!o_valid || i_ready)
//           o_valid/o_data  registered beat, i_ready downstream ready
module axis_pipe_reg #(
   parameter int WIDTH = 8
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_en,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   assign o_en    = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_en) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/axis_lrelu_config_framer.sv
// rtl/axis_lrelu_config_framer.sv - frames config + data beats for the LReLU engine stream
// Purpose : For each command (3x3 or 1x1), emits the exact number of config beats. The
//           tuser is_1x1 bit is set on these beats. It then forwards conv data beats up to
//           and including the data tlast.
// Ports   : aclk/aresetn  clock, synchronous active-low reset
//           s_cmd_*       iteration command (is_1x1 selects config length)
//           s_cfg_*       config payload from DMA
//           s_data_*      conv output data with keep/user/last
//           m_axis_*      registered output stream to the LReLU engine
//           err_cfg_len   sticky: DMA tlast disagreed with the expected config length
module axis_lrelu_config_framer
   import axis_lrelu_config_framer_pkg::*;
#(
   parameter int DATA_WIDTH       = 256,
   parameter int TUSER_WIDTH      = 8,
   parameter int I_IS_1X1         = LRELU_I_IS_1X1,
   parameter int BEATS_CONFIG_3X3 = LRELU_BEATS_CONFIG_3X3,
   parameter int BEATS_CONFIG_1X1 = LRELU_BEATS_CONFIG_1X1
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      s_cmd_tvalid,
   output logic                      s_cmd_tready,
   input  logic                      s_cmd_is_1x1,
   input  logic                      s_cfg_tvalid,
   output logic                      s_cfg_tready,
   input  logic [DATA_WIDTH-1:0]     s_cfg_tdata,
   input  logic                      s_cfg_tlast,
   input  logic                      s_data_tvalid,
   output logic                      s_data_tready,
   input  logic [DATA_WIDTH-1:0]     s_data_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s_data_tkeep,
   input  logic [TUSER_WIDTH-1:0]    s_data_tuser,
   input  logic                      s_data_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic                      m_axis_tlast,
   output logic                      err_cfg_len
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam int BEAT_W = DATA_WIDTH + KEEP_W + TUSER_WIDTH + 1;
   localparam int CNT_W  = $clog2(BEATS_CONFIG_3X3 > BEATS_CONFIG_1X1 ?
                                  BEATS_CONFIG_3X3 : BEATS_CONFIG_1X1);

   logic [1:0]             r_state;
   logic [CNT_W-1:0]       r_count;
   logic                   r_is_1x1;
   logic                   r_err;

   logic                   w_en;
   logic                   w_cmd_hs;
   logic                   w_cfg_hs;
   logic                   w_data_hs;
   logic                   w_cnt_zero;
   logic [TUSER_WIDTH-1:0] w_cfg_user;
   logic [BEAT_W-1:0]      w_beat;
   logic [BEAT_W-1:0]      w_m_beat;

   // Only the ready of the current state is raised, so early traffic on other inputs waits
   assign s_cmd_tready  = (r_state == ST_IDLE)   && w_en;
   assign s_cfg_tready  = (r_state == ST_CONFIG) && w_en;
   assign s_data_tready = (r_state == ST_DATA)   && w_en;

   assign w_cmd_hs   = s_cmd_tvalid  && s_cmd_tready;
   assign w_cfg_hs   = s_cfg_tvalid  && s_cfg_tready;
   assign w_data_hs  = s_data_tvalid && s_data_tready;
   assign w_cnt_zero = (r_count == '0);

   always_comb begin
      w_cfg_user           = '0;
      w_cfg_user[I_IS_1X1] = r_is_1x1;
      if (r_state == ST_CONFIG) begin
         // Config beats never carry tlast; the DMA's tlast is only checked, not forwarded
         w_beat = {s_cfg_tdata, {KEEP_W{1'b1}}, w_cfg_user, 1'b0};
      end else begin
         w_beat = {s_data_tdata, s_data_tkeep, s_data_tuser, s_data_tlast};
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_is_1x1 <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_hs) begin
                  r_is_1x1 <= s_cmd_is_1x1;
                  r_count  <= s_cmd_is_1x1 ? CNT_W'(BEATS_CONFIG_1X1 - 1)
                                           : CNT_W'(BEATS_CONFIG_3X3 - 1);
                  r_state  <= ST_CONFIG;
               end
            end
            ST_CONFIG: begin
               if (w_cfg_hs) begin
                  // Length is governed by the counter; tlast only raises the error flag
                  if (s_cfg_tlast != w_cnt_zero) begin
                     r_err <= 1'b1;
                  end
                  if (w_cnt_zero) begin
                     r_state <= ST_DATA;
                  end else begin
                     r_count <= r_count - 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (w_data_hs && s_data_tlast) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign err_cfg_len = r_err;

   axis_pipe_reg #(
      .WIDTH (BEAT_W)
   ) u_out_reg (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_valid (w_cfg_hs || w_data_hs),
      .i_data  (w_beat),
      .o_en    (w_en),
      .i_ready (m_axis_tready),
      .o_valid (m_axis_tvalid),
      .o_data  (w_m_beat)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = w_m_beat;

endmodule

// File: tb/tb_axis_lrelu_config_framer.sv
// tb/tb_axis_lrelu_config_framer.sv - scoreboard bench for axis_lrelu_config_framer
module tb_axis_lrelu_config_framer;

   localparam int DW = 256;
   localparam int KW = 32;
   localparam int UW = 8;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          s_cmd_tvalid, s_cmd_tready, s_cmd_is_1x1;
   logic          s_cfg_tvalid, s_cfg_tready, s_cfg_tlast;
   logic [DW-1:0] s_cfg_tdata;
   logic          s_data_tvalid, s_data_tready, s_data_tlast;
   logic [DW-1:0] s_data_tdata;
   logic [KW-1:0] s_data_tkeep;
   logic [UW-1:0] s_data_tuser;
   logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic [UW-1:0] m_axis_tuser;
   logic          err_cfg_len;

   axis_lrelu_config_framer dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_cmd_tvalid  (s_cmd_tvalid),
      .s_cmd_tready  (s_cmd_tready),
      .s_cmd_is_1x1  (s_cmd_is_1x1),
      .s_cfg_tvalid  (s_cfg_tvalid),
      .s_cfg_tready  (s_cfg_tready),
      .s_cfg_tdata   (s_cfg_tdata),
      .s_cfg_tlast   (s_cfg_tlast),
      .s_data_tvalid (s_data_tvalid),
      .s_data_tready (s_data_tready),
      .s_data_tdata  (s_data_tdata),
      .s_data_tkeep  (s_data_tkeep),
      .s_data_tuser  (s_data_tuser),
      .s_data_tlast  (s_data_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .err_cfg_len   (err_cfg_len)
   );

   always #5 aclk = ~aclk;

   int    errors = 0;
   int    checks = 0;
   int    cyc    = 0;
   bit    cmd_q[$];
   beat_t cfg_q[$];
   beat_t data_q[$];
   beat_t exp_q[$];
   int    out_cyc[$];
   int    cfg_hs_cyc[$];
   bit    bp_en = 0;
   int    bp_i  = 0;
   logic [3:0] bp_pat = 4'b1001;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Queue one iteration: command, config beats (tlast at position lastpos, 1-based),
   // data beats, and the output beats the framer must produce for it.
   task automatic add_iter(input bit is1x1, input int ncfg, input int lastpos,
                           input logic [7:0] cbase, input int ndata, input int ndexp,
                           input logic [7:0] dbase);
      beat_t b;
      int    nexp;
      nexp = is1x1 ? 5 : 9;
      cmd_q.push_back(is1x1);
      for (int i = 0; i < ncfg; i++) begin
         b.d = DW'(cbase + 8'(i)); b.k = '0; b.u = '0; b.l = (i + 1 == lastpos);
         cfg_q.push_back(b);
         if (i < nexp) begin
            b.k = '1; b.u = is1x1 ? 8'h04 : 8'h00; b.l = 1'b0;
            exp_q.push_back(b);
         end
      end
      for (int j = 0; j < ndata; j++) begin
         b.d = {8'h5A, 240'd0, dbase + 8'(j)};
         b.k = {24'hFF00F0, 8'(j)};
         b.u = 8'h30 + 8'(j);
         b.l = (j == ndata - 1);
         data_q.push_back(b);
         if (j < ndexp) exp_q.push_back(b);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge aclk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d beats missing, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge aclk);
      #2;
   endtask

   // Producers: present the queue head, pop it once a handshake was seen at the negedge
   initial begin
      bit hs;
      forever begin
         if (cmd_q.size() > 0) begin s_cmd_tvalid = 1; s_cmd_is_1x1 = cmd_q[0]; end
         else begin s_cmd_tvalid = 0; s_cmd_is_1x1 = 0; end
         @(negedge aclk); hs = s_cmd_tvalid && s_cmd_tready;
         @(posedge aclk); #1;
         if (hs && cmd_q.size() > 0) void'(cmd_q.pop_front());
      end
   end

   initial begin
      bit hs;
      forever begin
         if (cfg_q.size() > 0) begin
            s_cfg_tvalid = 1; s_cfg_tdata = cfg_q[0].d; s_cfg_tlast = cfg_q[0].l;
         end else begin
            s_cfg_tvalid = 0; s_cfg_tdata = '0; s_cfg_tlast = 0;
         end
         @(negedge aclk); hs = s_cfg_tvalid && s_cfg_tready;
         if (hs) cfg_hs_cyc.push_back(cyc);
         @(posedge aclk); #1;
         if (hs && cfg_q.size() > 0) void'(cfg_q.pop_front());
      end
   end

   initial begin
      bit hs;
      forever begin
         if (data_q.size() > 0) begin
            s_data_tvalid = 1; s_data_tdata = data_q[0].d; s_data_tkeep = data_q[0].k;
            s_data_tuser = data_q[0].u; s_data_tlast = data_q[0].l;
         end else begin
            s_data_tvalid = 0; s_data_tdata = '0; s_data_tkeep = '0;
            s_data_tuser = '0; s_data_tlast = 0;
         end
         @(negedge aclk); hs = s_data_tvalid && s_data_tready;
         @(posedge aclk); #1;
         if (hs && data_q.size() > 0) void'(data_q.pop_front());
      end
   end

   always @(posedge aclk) begin
      #1;
      if (bp_en) begin
         m_axis_tready = bp_pat[bp_i % 4];
         bp_i++;
      end
   end

   // Monitor: compares every output handshake with the scoreboard and checks stall stability
   bit            prev_stall = 0;
   logic [319:0]  prev_beat;
   initial begin
      beat_t e;
      logic [319:0] cur;
      forever begin
         @(negedge aclk);
         cur = 320'({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast});
         if (aresetn) begin
            if (prev_stall) begin
               chk("hold_valid", 320'(m_axis_tvalid), 320'(1));
               chk("hold_beat", cur, prev_beat);
            end
            if (m_axis_tvalid && m_axis_tready) begin
               out_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_beat: got %0h expected none", m_axis_tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_tdata", 320'(m_axis_tdata), 320'(e.d));
                  chk("out_tkeep", 320'(m_axis_tkeep), 320'(e.k));
                  chk("out_tuser", 320'(m_axis_tuser), 320'(e.u));
                  chk("out_tlast", 320'(m_axis_tlast), 320'(e.l));
               end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = cur;
         end else begin
            prev_stall = 0;
         end
      end
   end

   initial begin
      int n;
      aresetn = 0;
      m_axis_tready = 1;
      repeat (3) @(posedge aclk);
      #1 aresetn = 1;

      // Reset state
      @(negedge aclk);
      chk("rst_tvalid", 320'(m_axis_tvalid), 320'(0));
      chk("rst_tdata",  320'(m_axis_tdata),  320'(0));
      chk("rst_tlast",  320'(m_axis_tlast),  320'(0));
      chk("rst_err",    320'(err_cfg_len),   320'(0));
      chk("rst_cmd_rdy",  320'(s_cmd_tready),  320'(1));
      chk("rst_cfg_rdy",  320'(s_cfg_tready),  320'(0));
      chk("rst_data_rdy", 320'(s_data_tready), 320'(0));

      // 3x3 iteration with latency check
      out_cyc.delete(); cfg_hs_cyc.delete();
      add_iter(0, 9, 9, 8'h01, 4, 4, 8'hA0);
      drain("it3x3");
      checks++;
      if (out_cyc.size() < 1 || cfg_hs_cyc.size() < 1 || out_cyc[0] != cfg_hs_cyc[0] + 1) begin
         errors++;
         $display("FAIL latency: got out_cycles=%0d expected first cfg hs + 1", out_cyc.size());
      end
      chk("err_3x3", 320'(err_cfg_len), 320'(0));

      // 1x1 iteration with an early 6th config beat that must stay held
      add_iter(1, 6, 5, 8'h11, 2, 2, 8'hB0);
      drain("it1x1");
      @(negedge aclk);
      chk("early_cfg_held", 320'(cfg_q.size()), 320'(1));
      chk("cfg_rdy_idle",   320'(s_cfg_tready), 320'(0));
      chk("err_1x1",        320'(err_cfg_len),  320'(0));
      @(posedge aclk); #2;
      cfg_q.delete(); s_cfg_tvalid = 0;
      repeat (2) @(posedge aclk); #2;

      // Backpressure 1,0,0,1 on the same 3x3 traffic
      bp_i = 0; bp_en = 1;
      add_iter(0, 9, 9, 8'h01, 4, 4, 8'hA0);
      drain("bp");
      bp_en = 0; m_axis_tready = 1;
      repeat (2) @(posedge aclk); #2;

      // Config length error: DMA tlast on beat 5 of a 3x3
      chk("err_before", 320'(err_cfg_len), 320'(0));
      add_iter(0, 9, 5, 8'h21, 2, 2, 8'hC0);
      n = 0;
      while (cfg_q.size() > 4 && n < 200) begin @(posedge aclk); #2; n++; end
      @(negedge aclk);
      chk("err_set", 320'(err_cfg_len), 320'(1));
      drain("lenerr");
      chk("err_sticky", 320'(err_cfg_len), 320'(1));

      // Reset in the middle of DATA after 2 of 4 data beats
      add_iter(0, 9, 9, 8'h31, 4, 1, 8'hD0);
      n = 0;
      while (data_q.size() > 2 && n < 200) begin @(posedge aclk); #2; n++; end
      aresetn = 0;
      cmd_q.delete(); cfg_q.delete(); data_q.delete();
      s_cmd_tvalid = 0; s_cfg_tvalid = 0; s_data_tvalid = 0;
      chk("pre_rst_drained", 320'(exp_q.size()), 320'(0));
      exp_q.delete();
      @(posedge aclk); #1 aresetn = 1;
      @(negedge aclk);
      chk("midrst_tvalid",   320'(m_axis_tvalid), 320'(0));
      chk("midrst_data_rdy", 320'(s_data_tready), 320'(0));
      chk("midrst_cmd_rdy",  320'(s_cmd_tready),  320'(1));
      chk("midrst_err",      320'(err_cfg_len),   320'(0));
      @(posedge aclk); #2;
      add_iter(1, 5, 5, 8'h41, 3, 3, 8'hE0);
      drain("after_rst");

      // Back-to-back 1x1 iterations with single data beats: cfg x5, data, bubble, cfg x5, data
      out_cyc.delete();
      add_iter(1, 5, 5, 8'h51, 1, 1, 8'hF0);
      add_iter(1, 5, 5, 8'h61, 1, 1, 8'hF8);
      drain("b2b");
      checks++;
      if (out_cyc.size() != 12) begin
         errors++;
         $display("FAIL b2b_count: got %0d expected 12", out_cyc.size());
      end else begin
         chk("b2b_first_run", 320'(out_cyc[5] - out_cyc[0]), 320'(5));
         chk("b2b_bubble",    320'(out_cyc[6] - out_cyc[5]), 320'(2));
         chk("b2b_second_run", 320'(out_cyc[11] - out_cyc[6]), 320'(5));
      end
      chk("b2b_err", 320'(err_cfg_len), 320'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/axis_lrelu_config_framer.md
Name: axis_lrelu_config_framer

Overview:
- Upstream transmitter for the LReLU engine's slave stream.
- Per iteration it takes one command (3x3 or 1x1) and emits exactly the config beats the engine expects. It then forwards the conv-output data beats until the data tlast.
- Output is a single registered AXI-Stream carrying tdata/tkeep/tuser/tlast, with the tuser is_1x1 bit valid on the config beats.
- Sits between the config DMA / conv core and the LReLU engine's s_axis port.

Parameters:
- DATA_WIDTH, 256: full beat width (COPIES*GROUPS*MEMBERS*UNITS*WORD_WIDTH_ACC in system).
- TUSER_WIDTH, 8: MEMBERS*TUSER_WIDTH_LRELU_IN in system.
- I_IS_1X1, 2: bit index of is_1x1 in tuser.
- BEATS_CONFIG_3X3, 9: total config beats per 3x3 iteration (D1+A2+B6).
- BEATS_CONFIG_1X1, 5: total config beats per 1x1 iteration (D1+A2+B2).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- s_cmd_tvalid  in  1  iteration command valid.
- s_cmd_tready  out  1  command accepted.
- s_cmd_is_1x1  in  1  1 = 1x1 iteration, 0 = 3x3.
- s_cfg_tvalid  in  1  config beat valid.
- s_cfg_tready  out  1  config ready.
- s_cfg_tdata  in  DATA_WIDTH  config payload.
- s_cfg_tlast  in  1  DMA marks last config beat.
- s_data_tvalid  in  1  conv data valid.
- s_data_tready  out  1  conv data ready.
- s_data_tdata  in  DATA_WIDTH  conv data.
- s_data_tkeep  in  DATA_WIDTH/8  byte keep.
- s_data_tuser  in  TUSER_WIDTH  per-beat user.
- s_data_tlast  in  1  last data beat of iteration.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  DATA_WIDTH/8  output keep.
- m_axis_tuser  out  TUSER_WIDTH  output user.
- m_axis_tlast  out  1  output last.
- err_cfg_len  out  1  sticky config-length mismatch flag.

Behaviour:
- Reset (aresetn=0 at posedge):
  - state=IDLE, count=0, is_1x1_q=0, err_cfg_len=0.
  - m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0.
  - Any in-flight iteration is abandoned; no partial beat is emitted after reset.
- Output register: a single pipeline stage, en = !m_axis_tvalid || m_axis_tready.
  - Upstream readies below are all gated by en.
  - Latency from input handshake to m_axis_tvalid is 1 cycle.
  - Full throughput when m_axis_tready is held at 1.
  - Output fields hold stable while tvalid=1 and tready=0.
- States:
  - IDLE:
    - s_cmd_tready=en; the other readies are 0.
    - On cmd handshake: latch is_1x1_q; count = (is_1x1 ? BEATS_CONFIG_1X1 : BEATS_CONFIG_3X3) - 1; go to CONFIG.
  - CONFIG:
    - s_cfg_tready=en; the other readies are 0.
    - Each cfg handshake loads the output register with:
      - tdata = s_cfg_tdata
      - tkeep = all ones
      - tuser = 0 except bit I_IS_1X1 = is_1x1_q
      - tlast = 0
    - If count==0 on handshake, go to DATA; otherwise count decrements.
  - DATA:
    - s_data_tready=en; the other readies are 0.
    - Each handshake passes tdata/tkeep/tuser/tlast unchanged.
    - On handshake with s_data_tlast=1, go to IDLE.
- Never emitted on m_axis:
  - a config beat carrying tlast=1;
  - a data beat before the config count has completed.
- Back-to-back iterations:
  - A command is accepted in the cycle after the data tlast handshake (one IDLE cycle minimum).
  - That IDLE cycle produces a bubble on m_axis unless the output is stalled.
- A single-beat data iteration (tlast on the first data beat) is legal.
- Early data or config while in another state is held off (ready=0) and is not dropped.
- err_cfg_len is set, and stays set until reset, when either:
  - a cfg handshake has s_cfg_tlast=1 while count!=0; or
  - a cfg handshake has s_cfg_tlast=0 while count==0.
  - Beat counting follows count only and ignores s_cfg_tlast.
- Simultaneous cmd_valid and data_valid in IDLE: only the cmd is taken.

Decomposition:
- Shared package/params include:
  - state encodings IDLE=0, CONFIG=1, DATA=2;
  - BEATS_CONFIG_3X3/1X1 and I_IS_1X1, sourced from the same defines the LReLU engine uses so the two ends cannot disagree.
- One natural sub-module: axis_pipe_reg, the single-stage valid/ready output register, reusable elsewhere.
- The FSM, counter and mux stay in the top module.

Test Plan:
- 3x3 iteration: cmd is_1x1=0, 9 cfg beats 0x01..0x09 (tlast on 9th), 4 data beats 0xA0..0xA3 (tlast on 0xA3), tready=1 → m emits 9 beats with tuser[2]=0 and tlast=0, then 4 data beats with tlast only on 0xA3; err_cfg_len=0; first output 1 cycle after first cfg handshake.
- 1x1 iteration: cmd is_1x1=1, 5 cfg beats → exactly 5 beats with tuser[2]=1, then data passthrough; the 6th cfg beat presented early sees s_cfg_tready=0 until the next cmd.
- Backpressure: m_axis_tready toggling 1,0,0,1 during CONFIG → no beat lost or duplicated; held beats stable; total beat count and order match the unstalled run.
- Config length error: 3x3 cmd with s_cfg_tlast on beat 5 → err_cfg_len=1 from the next cycle; the framer still emits 9 config beats before DATA.
- Reset mid-DATA: aresetn=0 for 1 cycle after 2 of 4 data beats → m_axis_tvalid=0 next cycle, state IDLE, s_data_tready=0; a new cmd runs a clean iteration.
- Back-to-back: two 1x1 iterations with 1 data beat each, all valids high → output sequence cfg×5, data, bubble, cfg×5, data.
